// File: rtl/axi_l_req_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite BFM request port among requesters.
// Independent read/write arbiters; an in-order ID FIFO steers read data back.
module axi_l_req_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = 512,
   parameter int MASK_WIDTH     = DATA_WIDTH / 8,
   parameter int ID_W           = $clog2(NUM_REQ),
   parameter int RD_OUTSTANDING = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_REQ-1:0]                   req_rd_en,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_rd_addr,
   output logic [NUM_REQ-1:0]                   req_rd_gnt,
   output logic [NUM_REQ-1:0]                   req_rd_data_vld,
   output logic [DATA_WIDTH-1:0]                req_rd_data,
   input  logic [NUM_REQ-1:0]                   req_wr_en,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_wr_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_wr_data,
   input  logic [NUM_REQ*MASK_WIDTH-1:0]        req_wr_strb,
   output logic [NUM_REQ-1:0]                   req_wr_gnt,
   input  logic                                 normal_rd_cmd_rdy,
   output logic [ADDR_WIDTH-1:0]                normal_rd_addr,
   output logic                                 normal_rd_en,
   input  logic                                 normal_rd_data_vld,
   input  logic [DATA_WIDTH-1:0]                normal_rd_data,
   input  logic                                 normal_wr_cmd_rdy,
   output logic [ADDR_WIDTH-1:0]                normal_wr_addr,
   output logic [DATA_WIDTH-1:0]                normal_wr_data,
   output logic [MASK_WIDTH-1:0]                normal_wr_datastrb,
   output logic [$clog2(RD_OUTSTANDING+1)-1:0]  rd_outstanding,
   output logic                                 err_unexp_rdata
);

   localparam int CNT_W = $clog2(RD_OUTSTANDING + 1);
   localparam int PTR_W = (RD_OUTSTANDING > 1) ? $clog2(RD_OUTSTANDING) : 1;

   logic [ID_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [ID_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [ID_W-1:0]  fifo_q [RD_OUTSTANDING];

   logic [ID_W:0]    rd_pick, wr_pick;
   logic [ID_W-1:0]  rd_idx, wr_idx;
   logic             rd_allow, wr_allow;
   logic             push, pop;

   // First requester at or after ptr, wrapping; MSB flags a hit.
   function automatic logic [ID_W:0] rr_pick(
      input logic [NUM_REQ-1:0] req,
      input logic [ID_W-1:0]    ptr
   );
      logic [ID_W:0] r;
      r = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!r[ID_W] && req[i] && i >= int'(ptr)) begin
            r = {1'b1, ID_W'(i)};
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!r[ID_W] && req[i]) begin
            r = {1'b1, ID_W'(i)};
         end
      end
      return r;
   endfunction

   // Read arbitration: limit check uses the registered count only.
   always_comb begin
      rd_allow = rst_n && normal_rd_cmd_rdy &&
                 (cnt_q < CNT_W'(RD_OUTSTANDING));
      rd_pick  = rr_pick(req_rd_en, rd_ptr_q);
      rd_idx   = rd_pick[ID_W-1:0];
      push     = rd_allow && rd_pick[ID_W];
      req_rd_gnt     = '0;
      normal_rd_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (push && rd_idx == ID_W'(i)) begin
            req_rd_gnt[i]  = 1'b1;
            normal_rd_addr = req_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
      normal_rd_en = push;
   end

   // Write arbitration: winner's command drives the BFM, else all zero.
   always_comb begin
      wr_allow = rst_n && normal_wr_cmd_rdy;
      wr_pick  = rr_pick(req_wr_en, wr_ptr_q);
      wr_idx   = wr_pick[ID_W-1:0];
      req_wr_gnt         = '0;
      normal_wr_addr     = '0;
      normal_wr_data     = '0;
      normal_wr_datastrb = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (wr_allow && wr_pick[ID_W] && wr_idx == ID_W'(i)) begin
            req_wr_gnt[i]  = 1'b1;
            normal_wr_addr = req_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            normal_wr_data = req_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            normal_wr_datastrb =
               req_wr_strb[i*MASK_WIDTH +: MASK_WIDTH];
         end
      end
   end

   // Read return: steer valid to the FIFO head owner.
   always_comb begin
      pop = rst_n && normal_rd_data_vld && (cnt_q != '0);
      req_rd_data_vld = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_rd_data_vld[i] = pop && (fifo_q[head_q] == ID_W'(i));
      end
      req_rd_data = normal_rd_data;
   end

   // Next-state for pointers, FIFO indices, count and error flag.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      head_d   = head_q;
      tail_d   = tail_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      if (push) begin
         rd_ptr_d = (rd_idx == ID_W'(NUM_REQ-1)) ? '0 :
                    rd_idx + ID_W'(1);
         tail_d   = (tail_q == PTR_W'(RD_OUTSTANDING-1)) ? '0 :
                    tail_q + PTR_W'(1);
      end
      if (wr_allow && wr_pick[ID_W]) begin
         wr_ptr_d = (wr_idx == ID_W'(NUM_REQ-1)) ? '0 :
                    wr_idx + ID_W'(1);
      end
      if (pop) begin
         head_d = (head_q == PTR_W'(RD_OUTSTANDING-1)) ? '0 :
                  head_q + PTR_W'(1);
      end
      if (push && !pop) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      if (rst_n && normal_rd_data_vld && cnt_q == '0) begin
         err_d = 1'b1;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         head_q   <= '0;
         tail_q   <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   // ID FIFO storage; validity is tracked by head/tail/count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[tail_q] <= rd_idx;
      end
   end

   assign rd_outstanding  = cnt_q;
   assign err_unexp_rdata = err_q;

endmodule

// File: tb/tb_axi_l_req_arbiter.sv
// Self-checking bench for axi_l_req_arbiter.
// Read owners are queued at grant time and checked at data return.
module tb_axi_l_req_arbiter;

   localparam int N  = 4;
   localparam int AW = 64;
   localparam int DW = 512;
   localparam int MW = DW / 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_rd_en;
   logic [N*AW-1:0] req_rd_addr;
   logic [N-1:0]    req_rd_gnt;
   logic [N-1:0]    req_rd_data_vld;
   logic [DW-1:0]   req_rd_data;
   logic [N-1:0]    req_wr_en;
   logic [N*AW-1:0] req_wr_addr;
   logic [N*DW-1:0] req_wr_data;
   logic [N*MW-1:0] req_wr_strb;
   logic [N-1:0]    req_wr_gnt;
   logic            normal_rd_cmd_rdy;
   logic [AW-1:0]   normal_rd_addr;
   logic            normal_rd_en;
   logic            normal_rd_data_vld;
   logic [DW-1:0]   normal_rd_data;
   logic            normal_wr_cmd_rdy;
   logic [AW-1:0]   normal_wr_addr;
   logic [DW-1:0]   normal_wr_data;
   logic [MW-1:0]   normal_wr_datastrb;
   logic [4:0]      rd_outstanding;
   logic            err_unexp_rdata;

   int tests = 0;
   int fails = 0;
   int exp_q[$];
   logic [N-1:0] one = 1;

   axi_l_req_arbiter dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .req_rd_en          (req_rd_en),
      .req_rd_addr        (req_rd_addr),
      .req_rd_gnt         (req_rd_gnt),
      .req_rd_data_vld    (req_rd_data_vld),
      .req_rd_data        (req_rd_data),
      .req_wr_en          (req_wr_en),
      .req_wr_addr        (req_wr_addr),
      .req_wr_data        (req_wr_data),
      .req_wr_strb        (req_wr_strb),
      .req_wr_gnt         (req_wr_gnt),
      .normal_rd_cmd_rdy  (normal_rd_cmd_rdy),
      .normal_rd_addr     (normal_rd_addr),
      .normal_rd_en       (normal_rd_en),
      .normal_rd_data_vld (normal_rd_data_vld),
      .normal_rd_data     (normal_rd_data),
      .normal_wr_cmd_rdy  (normal_wr_cmd_rdy),
      .normal_wr_addr     (normal_wr_addr),
      .normal_wr_data     (normal_wr_data),
      .normal_wr_datastrb (normal_wr_datastrb),
      .rd_outstanding     (rd_outstanding),
      .err_unexp_rdata    (err_unexp_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [AW-1:0] raddr(int i);
      return 64'h1000 + 64'(i * 16);
   endfunction
   function automatic logic [AW-1:0] waddr(int i);
      return 64'h2000 + 64'(i * 8);
   endfunction
   function automatic logic [DW-1:0] wdata(int i);
      return {16{32'hC0DE0000 + 32'(i)}};
   endfunction
   function automatic logic [MW-1:0] wstrb(int i);
      logic [MW-1:0] s;
      s = 64'hFF;
      return s << (i * 8);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_payloads();
      for (int i = 0; i < N; i++) begin
         req_rd_addr[i*AW +: AW] = raddr(i);
         req_wr_addr[i*AW +: AW] = waddr(i);
         req_wr_data[i*DW +: DW] = wdata(i);
         req_wr_strb[i*MW +: MW] = wstrb(i);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_rd_en = '0;
      req_wr_en = '0;
      normal_rd_data_vld = 1'b0;
      normal_rd_cmd_rdy = 1'b1;
      normal_wr_cmd_rdy = 1'b1;
      load_payloads();
      tick();
      tick();
      rst_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic ret_beat(input logic [DW-1:0] d);
      int o;
      normal_rd_data_vld = 1'b1;
      normal_rd_data = d;
      @(negedge clk);
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL ret_sb: got vld %b want none queued",
                  req_rd_data_vld);
      end else begin
         o = exp_q.pop_front();
         if (req_rd_data_vld !== (one << o)) begin
            fails++;
            $display("FAIL ret_vld: got %b want %b",
                     req_rd_data_vld, one << o);
         end
      end
      tests++;
      if (req_rd_data !== d) begin
         fails++;
         $display("FAIL ret_data: got %h want %h", req_rd_data, d);
      end
      tick();
      normal_rd_data_vld = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      load_payloads();
      req_rd_en = '1;
      req_wr_en = '1;
      normal_rd_cmd_rdy = 1'b1;
      normal_wr_cmd_rdy = 1'b1;
      normal_rd_data_vld = 1'b1;
      normal_rd_data = {16{32'h5A5A0001}};
      tick();
      @(negedge clk);
      tests++;
      if ({req_rd_gnt, req_wr_gnt, normal_rd_en, req_rd_data_vld}
          !== '0 || normal_wr_datastrb !== '0) begin
         fails++;
         $display("FAIL rst_outs: got rg %b wg %b en %b strb %h",
                  req_rd_gnt, req_wr_gnt, normal_rd_en,
                  normal_wr_datastrb);
      end
      tests++;
      if (req_rd_data !== {16{32'h5A5A0001}}) begin
         fails++;
         $display("FAIL rst_rdata: got %h", req_rd_data);
      end
      tests++;
      if (rd_outstanding !== 5'd0 || err_unexp_rdata !== 1'b0) begin
         fails++;
         $display("FAIL rst_state: got cnt %0d err %b want 0 0",
                  rd_outstanding, err_unexp_rdata);
      end
   endtask

   task automatic test_single();
      do_reset();
      req_rd_addr[2*AW +: AW] = 64'h40;
      req_rd_en = 4'b0100;
      @(negedge clk);
      tests++;
      if (req_rd_gnt !== 4'b0100 || normal_rd_en !== 1'b1 ||
          normal_rd_addr !== 64'h40) begin
         fails++;
         $display("FAIL single_gnt: got %b %b %h want 0100 1 40",
                  req_rd_gnt, normal_rd_en, normal_rd_addr);
      end
      exp_q.push_back(2);
      tick();
      req_rd_en = '0;
      @(negedge clk);
      tests++;
      if (req_rd_gnt !== '0 || normal_rd_addr !== '0 ||
          rd_outstanding !== 5'd1) begin
         fails++;
         $display("FAIL single_idle: got %b %h cnt %0d",
                  req_rd_gnt, normal_rd_addr, rd_outstanding);
      end
      tick();
      ret_beat({16{32'hDEAD0002}});
      @(negedge clk);
      tests++;
      if (rd_outstanding !== 5'd0) begin
         fails++;
         $display("FAIL single_cnt: got %0d want 0", rd_outstanding);
      end
      tick();
   endtask

   task automatic test_fairness();
      int e;
      do_reset();
      req_rd_en = '1;
      req_wr_en = '1;
      for (int k = 0; k < 8; k++) begin
         e = k % N;
         @(negedge clk);
         tests++;
         if (req_rd_gnt !== (one << e) || normal_rd_addr !== raddr(e))
         begin
            fails++;
            $display("FAIL fair_rd%0d: got %b %h want %b %h", k,
                     req_rd_gnt, normal_rd_addr, one << e, raddr(e));
         end
         tests++;
         if (req_wr_gnt !== (one << e) || normal_wr_addr !== waddr(e)
             || normal_wr_data !== wdata(e) ||
             normal_wr_datastrb !== wstrb(e)) begin
            fails++;
            $display("FAIL fair_wr%0d: got %b %h %h want %b", k,
                     req_wr_gnt, normal_wr_addr, normal_wr_datastrb,
                     one << e);
         end
         exp_q.push_back(e);
         tick();
      end
      req_rd_en = '0;
      req_wr_en = '0;
      @(negedge clk);
      tests++;
      if (rd_outstanding !== 5'd8) begin
         fails++;
         $display("FAIL fair_cnt: got %0d want 8", rd_outstanding);
      end
      tick();
      for (int k = 0; k < 8; k++) ret_beat({16{32'(k + 100)}});
   endtask

   task automatic test_ordering();
      int ord[3] = '{3, 1, 0};
      do_reset();
      for (int k = 0; k < 3; k++) begin
         req_rd_en = one << ord[k];
         @(negedge clk);
         tests++;
         if (req_rd_gnt !== (one << ord[k])) begin
            fails++;
            $display("FAIL order_gnt%0d: got %b want %b", k,
                     req_rd_gnt, one << ord[k]);
         end
         exp_q.push_back(ord[k]);
         tick();
      end
      req_rd_en = '0;
      for (int k = 0; k < 3; k++) ret_beat({16{32'(k + 7)}});
   endtask

   task automatic test_limit();
      do_reset();
      req_rd_en = 4'b0001;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         tests++;
         if (req_rd_gnt !== 4'b0001) begin
            fails++;
            $display("FAIL limit_gnt%0d: got %b want 0001", k,
                     req_rd_gnt);
         end
         exp_q.push_back(0);
         tick();
      end
      @(negedge clk);
      tests++;
      if (rd_outstanding !== 5'd16 || req_rd_gnt !== '0 ||
          normal_rd_en !== 1'b0) begin
         fails++;
         $display("FAIL limit_full: got cnt %0d gnt %b en %b",
                  rd_outstanding, req_rd_gnt, normal_rd_en);
      end
      tick();
      normal_rd_data_vld = 1'b1;
      @(negedge clk);
      tests++;
      if (req_rd_gnt !== '0 || req_rd_data_vld !== 4'b0001) begin
         fails++;
         $display("FAIL limit_popfull: got gnt %b vld %b want 0 0001",
                  req_rd_gnt, req_rd_data_vld);
      end
      void'(exp_q.pop_front());
      tick();
      @(negedge clk);
      tests++;
      if (rd_outstanding !== 5'd15 || req_rd_gnt !== 4'b0001 ||
          req_rd_data_vld !== 4'b0001) begin
         fails++;
         $display("FAIL limit_pp: got cnt %0d gnt %b vld %b",
                  rd_outstanding, req_rd_gnt, req_rd_data_vld);
      end
      tick();
      normal_rd_data_vld = 1'b0;
      req_rd_en = '0;
      @(negedge clk);
      tests++;
      if (rd_outstanding !== 5'd15) begin
         fails++;
         $display("FAIL limit_hold: got %0d want 15", rd_outstanding);
      end
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      normal_wr_cmd_rdy = 1'b0;
      req_wr_en = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tests++;
         if (req_wr_gnt !== '0 || normal_wr_datastrb !== '0) begin
            fails++;
            $display("FAIL bp_hold%0d: got gnt %b strb %h", k,
                     req_wr_gnt, normal_wr_datastrb);
         end
         tick();
      end
      normal_wr_cmd_rdy = 1'b1;
      @(negedge clk);
      tests++;
      if (req_wr_gnt !== 4'b0010 || normal_wr_addr !== waddr(1) ||
          normal_wr_data !== wdata(1) ||
          normal_wr_datastrb !== wstrb(1)) begin
         fails++;
         $display("FAIL bp_gnt: got %b %h %h want 0010 %h", req_wr_gnt,
                  normal_wr_addr, normal_wr_datastrb, waddr(1));
      end
      tick();
      req_wr_strb[2*MW +: MW] = '0;
      req_wr_en = 4'b0100;
      @(negedge clk);
      tests++;
      if (req_wr_gnt !== 4'b0100 || normal_wr_datastrb !== '0 ||
          normal_wr_addr !== waddr(2)) begin
         fails++;
         $display("FAIL bp_zstrb: got %b %h want 0100 0", req_wr_gnt,
                  normal_wr_datastrb);
      end
      tick();
      req_wr_en = '0;
   endtask

   task automatic test_errors();
      do_reset();
      normal_rd_data_vld = 1'b1;
      @(negedge clk);
      tests++;
      if (req_rd_data_vld !== '0) begin
         fails++;
         $display("FAIL err_vld: got %b want 0", req_rd_data_vld);
      end
      tick();
      normal_rd_data_vld = 1'b0;
      @(negedge clk);
      tests++;
      if (err_unexp_rdata !== 1'b1) begin
         fails++;
         $display("FAIL err_flag: got %b want 1", err_unexp_rdata);
      end
      req_rd_en = '1;
      for (int k = 0; k < 5; k++) tick();
      req_rd_en = '0;
      @(negedge clk);
      tests++;
      if (rd_outstanding !== 5'd5 || err_unexp_rdata !== 1'b1) begin
         fails++;
         $display("FAIL err_pre: got cnt %0d err %b want 5 1",
                  rd_outstanding, err_unexp_rdata);
      end
      tick();
      rst_n = 1'b0;
      req_rd_en = '1;
      req_wr_en = '1;
      @(negedge clk);
      tests++;
      if (req_rd_gnt !== '0 || req_wr_gnt !== '0 ||
          normal_rd_en !== 1'b0 || normal_wr_datastrb !== '0) begin
         fails++;
         $display("FAIL err_inrst: got %b %b %b %h", req_rd_gnt,
                  req_wr_gnt, normal_rd_en, normal_wr_datastrb);
      end
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      tests++;
      if (rd_outstanding !== 5'd0 || err_unexp_rdata !== 1'b0) begin
         fails++;
         $display("FAIL err_post: got cnt %0d err %b want 0 0",
                  rd_outstanding, err_unexp_rdata);
      end
      tests++;
      if (req_rd_gnt !== 4'b0001 || req_wr_gnt !== 4'b0001) begin
         fails++;
         $display("FAIL err_ptr: got rd %b wr %b want 0001",
                  req_rd_gnt, req_wr_gnt);
      end
      tick();
      req_rd_en = '0;
      req_wr_en = '0;
   endtask

   initial begin
      normal_rd_data = '0;
      test_reset();
      test_single();
      test_fairness();
      test_ordering();
      test_limit();
      test_backpressure();
      test_errors();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
